regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 116 +++++++++++
 tb/tb_regfile_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised register file with two combinational read ports and one write port.
// It has same-cycle write bypass and one pending-write flag per register.
// A bulk clear zeroes one register per cycle over DEPTH cycles.
module regfile_param #(
  parameter int  WIDTH    = 16,
  parameter int  DEPTH    = 16,
  parameter bit  ZERO_REG = 1'b0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WriteReg,
  input  logic [AW-1:0]    DstReg,
  input  logic [WIDTH-1:0] DstData,
  input  logic [AW-1:0]    SrcReg1,
  input  logic [AW-1:0]    SrcReg2,
  output logic [WIDTH-1:0] SrcData1,
  output logic [WIDTH-1:0] SrcData2,
  input  logic             mark_en,
  input  logic [AW-1:0]    mark_reg,
  output logic             busy1,
  output logic             busy2,
  input  logic             clr_req,
  output logic             clr_busy
);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             idle;
  logic             wr_en;
  logic             mark_ok;

  // Qualify write and mark requests: only honoured in IDLE, never for a hard-wired zero register
  always_comb begin
    idle    = (state_q == S_IDLE);
    wr_en   = idle && WriteReg && !(ZERO_REG && (DstReg == '0));
    mark_ok = idle && mark_en  && !(ZERO_REG && (mark_reg == '0));
  end

  // Read ports: stored value, overridden by the in-flight write, which also hides the busy flag
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    SrcData1 = regs_q[SrcReg1];
    SrcData2 = regs_q[SrcReg2];
    busy1    = idle && pend_q[SrcReg1];
    busy2    = idle && pend_q[SrcReg2];
    if (wr_en && (DstReg == SrcReg1)) begin
      SrcData1 = DstData;
      busy1    = 1'b0;
    end
    if (wr_en && (DstReg == SrcReg2)) begin
      SrcData2 = DstData;
      busy2    = 1'b0;
    end
  end

  // Next state of the clear FSM, the register array and the pending scoreboard
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          regs_d[DstReg] = DstData;
          pend_d[DstReg] = 1'b0;
        end
        // A mark applied after the write-clear makes the set win on the same index
        if (mark_ok) begin
          pend_d[mark_reg] = 1'b1;
        end
        if (clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          pend_d  = '0;
        end
      end
      S_CLEAR: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the storage array is reset too, because reset must zero every register at once.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end

  assign clr_busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param.
// It runs a vector table, hand-written clear and reset sequences, a ZERO_REG instance,
// and random traffic compared against an array-based reference model.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: WIDTH=16, DEPTH=16, ZERO_REG=0
  logic        we = 1'b0, mk = 1'b0, clr = 1'b0;
  logic [3:0]  dst = '0, s1 = '0, s2 = '0, mr = '0;
  logic [15:0] data = '0, d1, d2;
  logic        b1, b2, cb;

  regfile_param dut (
    .clk(clk), .rst(rst), .WriteReg(we), .DstReg(dst), .DstData(data),
    .SrcReg1(s1), .SrcReg2(s2), .SrcData1(d1), .SrcData2(d2),
    .mark_en(mk), .mark_reg(mr), .busy1(b1), .busy2(b2),
    .clr_req(clr), .clr_busy(cb)
  );

  // ZERO_REG instance: WIDTH=32, DEPTH=32
  logic        z_we = 1'b0, z_mk = 1'b0, z_clr = 1'b0;
  logic [4:0]  z_dst = '0, z_s1 = '0, z_s2 = '0, z_mr = '0;
  logic [31:0] z_data = '0, z_d1, z_d2;
  logic        z_b1, z_b2, z_cb;

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .WriteReg(z_we), .DstReg(z_dst), .DstData(z_data),
    .SrcReg1(z_s1), .SrcReg2(z_s2), .SrcData1(z_d1), .SrcData2(z_d2),
    .mark_en(z_mk), .mark_reg(z_mr), .busy1(z_b1), .busy2(z_b2),
    .clr_req(z_clr), .clr_busy(z_cb)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic quiet_inputs();
    we = 1'b0; mk = 1'b0; clr = 1'b0;
    z_we = 1'b0; z_mk = 1'b0; z_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    quiet_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // One combinational-read vector applied in a single cycle
  typedef struct {
    logic        we;
    logic [3:0]  dst;
    logic [15:0] data;
    logic [3:0]  s1, s2;
    logic        mk;
    logic [3:0]  mr;
    logic [15:0] e1, e2;
    logic        eb1, eb2;
  } vec_t;

  vec_t tbl[12];

  // Reference model state for the random phase
  logic [15:0] m_mem [16];
  logic [15:0] m_pend;
  int          m_clr_left;

  int busy_cycles;

  initial begin
    // Write/readback, bypass and scoreboard behaviour, starting from the reset state
    tbl[0]  = '{1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd6, 1'b0, 4'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'd0, 16'h0000, 4'd5, 4'd6, 1'b0, 4'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd3, 16'h1234, 4'd3, 4'd3, 1'b0, 4'd0, 16'h1234, 16'h1234, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'd0, 16'h0000, 4'd3, 4'd5, 1'b0, 4'd0, 16'h1234, 16'hBEEF, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'd0, 16'h0000, 4'd7, 4'd3, 1'b1, 4'd7, 16'h0000, 16'h1234, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 4'd7, 16'h0777, 4'd7, 4'd3, 1'b0, 4'd0, 16'h0777, 16'h1234, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 1'b0, 4'd0, 16'h0777, 16'h0777, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'd7, 16'h0888, 4'd7, 4'd7, 1'b1, 4'd7, 16'h0888, 16'h0888, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'd0, 16'h0000, 4'd7, 4'd5, 1'b0, 4'd0, 16'h0888, 16'hBEEF, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 4'd5, 16'h0001, 4'd7, 4'd5, 1'b1, 4'd9, 16'h0888, 16'h0001, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'd0, 16'h0000, 4'd9, 4'd5, 1'b0, 4'd0, 16'h0000, 16'h0001, 1'b1, 1'b0};

    // Power-on reset and reset-state checks on both instances
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_d1", d1, 16'h0);
    check("rst_d2", d2, 16'h0);
    check("rst_b1", b1, 1'b0);
    check("rst_cb", cb, 1'b0);
    check("rst_z_cb", z_cb, 1'b0);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      we = tbl[i].we; dst = tbl[i].dst; data = tbl[i].data;
      s1 = tbl[i].s1; s2 = tbl[i].s2; mk = tbl[i].mk; mr = tbl[i].mr;
      #1;
      check($sformatf("vec%0d_d1", i), d1, tbl[i].e1);
      check($sformatf("vec%0d_d2", i), d2, tbl[i].e2);
      check($sformatf("vec%0d_b1", i), b1, tbl[i].eb1);
      check($sformatf("vec%0d_b2", i), b2, tbl[i].eb2);
    end

    // ZERO_REG instance: register 0 is hard-wired, register 31 is normal
    @(negedge clk);
    quiet_inputs();
    z_we = 1'b1; z_dst = 5'd0; z_data = 32'hDEADBEEF; z_mk = 1'b1; z_mr = 5'd0;
    z_s1 = 5'd0; z_s2 = 5'd0;
    #1;
    check("z_nobypass_d1", z_d1, 32'h0);
    check("z_nobusy_b1", z_b1, 1'b0);
    @(negedge clk);
    z_we = 1'b0; z_mk = 1'b0;
    #1;
    check("z_reg0_d1", z_d1, 32'h0);
    check("z_reg0_b2", z_b2, 1'b0);
    @(negedge clk);
    z_we = 1'b1; z_dst = 5'd31; z_data = 32'h12345678; z_s2 = 5'd31;
    #1;
    check("z_bypass31", z_d2, 32'h12345678);
    @(negedge clk);
    z_we = 1'b0;
    #1;
    check("z_read31", z_d2, 32'h12345678);
    check("z_read0", z_d1, 32'h0);

    // Bulk clear: fill with 0xFFFF, clear, drop a mid-clear write, write right after
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we = 1'b1; dst = 4'(i); data = 16'hFFFF;
    end
    @(negedge clk);
    we = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 40 && cb; k++) begin
      busy_cycles++;
      if (busy_cycles == 2) begin
        we = 1'b1; dst = 4'd2; data = 16'hAAAA; s1 = 4'd2; s2 = 4'd0;
        mk = 1'b1; mr = 4'd6; clr = 1'b1;
        #1;
        check("clr_no_bypass", d1, 16'hFFFF);
        check("clr_done_reads0", d2, 16'h0);
        check("clr_busy1_low", b1, 1'b0);
      end
      @(negedge clk);
      we = 1'b0; mk = 1'b0; clr = 1'b0;
    end
    check("clr_busy_cycles", busy_cycles, 16);
    we = 1'b1; dst = 4'd4; data = 16'h5555;
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s1 = 4'(i); s2 = 4'd6;
      #1;
      check($sformatf("post_clr_r%0d", i), d1, (i == 4) ? 16'h5555 : 16'h0);
      @(negedge clk);
    end
    check("post_clr_mark_ignored", b2, 1'b0);
    check("post_clr_cb", cb, 1'b0);

    // Asynchronous reset in the middle of a clear (cnt = 8)
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we = 1'b1; dst = 4'(i); data = 16'(i + 1);
    end
    @(negedge clk);
    we = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (8) @(negedge clk);
    s1 = 4'd15; s2 = 4'd7;
    #1;
    check("mid_clr_busy", cb, 1'b1);
    check("mid_clr_uncleared", d1, 16'd16);
    check("mid_clr_cleared", d2, 16'h0);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_cb", cb, 1'b0);
    check("async_rst_d1", d1, 16'h0);
    for (int i = 0; i < 16; i++) begin
      s2 = 4'(i);
      #1;
      check($sformatf("async_rst_r%0d", i), d2, 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    we = 1'b1; dst = 4'd9; data = 16'h0999;
    @(negedge clk);
    we = 1'b0; s1 = 4'd9;
    #1;
    check("after_rst_write", d1, 16'h0999);
    check("after_rst_cb", cb, 1'b0);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_pend     = '0;
    m_clr_left = 0;
    for (int n = 0; n < 600; n++) begin
      logic        idle_m, wr_m;
      logic [15:0] e1, e2;
      logic        eb1, eb2;
      @(negedge clk);
      we   = 1'($urandom_range(0, 1));
      dst  = 4'($urandom);
      data = 16'($urandom);
      s1   = ($urandom_range(0, 3) == 0) ? dst : 4'($urandom);
      s2   = ($urandom_range(0, 3) == 0) ? dst : 4'($urandom);
      mk   = ($urandom_range(0, 3) == 0);
      mr   = ($urandom_range(0, 1) == 0) ? dst : 4'($urandom);
      clr  = ($urandom_range(0, 39) == 0);
      #1;
      idle_m = (m_clr_left == 0);
      wr_m   = idle_m && we;
      e1  = (wr_m && dst == s1) ? data : m_mem[s1];
      e2  = (wr_m && dst == s2) ? data : m_mem[s2];
      eb1 = idle_m && m_pend[s1] && !(wr_m && dst == s1);
      eb2 = idle_m && m_pend[s2] && !(wr_m && dst == s2);
      check("rnd_d1", d1, e1);
      check("rnd_d2", d2, e2);
      check("rnd_b1", b1, eb1);
      check("rnd_b2", b2, eb2);
      check("rnd_cb", cb, !idle_m);
      if (idle_m) begin
        if (we) begin
          m_mem[dst]  = data;
          m_pend[dst] = 1'b0;
        end
        if (mk) m_pend[mr] = 1'b1;
        if (clr) begin
          m_pend     = '0;
          m_clr_left = 16;
        end
      end else begin
        m_mem[16 - m_clr_left] = '0;
        m_clr_left--;
      end
    end

    @(negedge clk);
    quiet_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
